// File: rtl/keccak_pkg.sv
// Shared Keccak slice-array definitions: geometry, slice word type and the
// rho lane-rotation offsets used by both the forward and inverse rotate stages.
package keccak_pkg;

  localparam int SLICES = 64;
  localparam int LANES  = 25;

  // Bit i of a slice word is lane i (i = x + 5*y).
  typedef logic [0:LANES-1] slice_t;

  localparam logic [5:0] RHO_OFFS [0:LANES-1] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

endpackage

// File: rtl/lane_rot64.sv
// Combinational 64-bit lane rotator; dir = 0 rotates right (out[z] = in[z+amt]),
// dir = 1 rotates left (out[z] = in[z-amt]), all indices mod 64.
module lane_rot64 (
  input  logic [63:0] din,
  input  logic [5:0]  amt,
  input  logic        dir,
  output logic [63:0] dout
);

  logic [5:0] idx;

  always_comb begin
    idx  = '0;
    dout = '0;
    for (int i = 0; i < 64; i++) begin
      idx     = dir ? (6'(i) - amt) : (6'(i) + amt);
      dout[i] = din[idx];
    end
  end

endmodule

// File: rtl/inv_rotate.sv
// Keccak rho-inverse stage: rotates each lane right by its rho offset, one lane
// per clock, in place. Optional sticky misuse flag `err` under INV_ROTATE_ERR_EN.
module inv_rotate
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  slice_t     wr_data,
  input  logic [5:0] rd_addr,
  output slice_t     rd_data,
  output logic       busy,
`ifdef INV_ROTATE_ERR_EN
  output logic       err,
`endif
  output logic       ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  slice_t      mem [0:SLICES-1];
  logic [63:0] lane_old;
  logic [63:0] lane_new;

  // Gather lane `cnt` across all slices so it can be rotated as one word.
  always_comb begin
    lane_old = '0;
    for (int z = 0; z < SLICES; z++) begin
      lane_old[z] = mem[z][cnt];
    end
  end

  lane_rot64 u_rot (
    .din  (lane_old),
    .amt  (RHO_OFFS[cnt]),
    .dir  (1'b0),
    .dout (lane_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      for (int z = 0; z < SLICES; z++) begin
        mem[z] <= '0;
      end
    end else begin
      ready <= 1'b0;
      if (wr_en && state != ST_RUN) begin
        mem[wr_addr] <= wr_data;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          for (int z = 0; z < SLICES; z++) begin
            mem[z][cnt] <= lane_new[z];
          end
          if (cnt == 5'(LANES - 1)) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
          ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INV_ROTATE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((wr_en || start) && state != ST_IDLE) begin
      err <= 1'b1;
    end
  end
`endif

  assign busy    = (state == ST_RUN);
  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_inv_rotate.sv
// Bench for inv_rotate: spec-level model of the slice array and handshake timing
// compared every cycle, plus directed literal vectors and forward/inverse round trips.
module tb_inv_rotate;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [0:24] wr_data;
  logic [5:0]  rd_addr;
  logic [0:24] rd_data;
  logic        busy;
  logic        ready;
`ifdef INV_ROTATE_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_rotate dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
`ifdef INV_ROTATE_ERR_EN
    .err     (err),
`endif
    .ready   (ready)
  );

  int rho_tb [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  // Model: m_t = -1 idle, 0..24 = lane about to be processed, 25 = done, 26 = ready cycle.
  logic [0:24] m_mem [64];
  int          m_t   = -1;
  logic        m_err = 1'b0;
  bit          checking = 1'b0;

  logic [0:24] s_mem [64];
  logic [0:24] f_mem [64];

  always @(posedge clk) begin : model
    logic [63:0] lane;
    if (rst) begin
      for (int z = 0; z < 64; z++) m_mem[z] <= '0;
      m_t   <= -1;
      m_err <= 1'b0;
    end else if (m_t >= 0 && m_t <= 24) begin
      for (int z = 0; z < 64; z++) lane[z] = m_mem[(z + rho_tb[m_t]) % 64][m_t];
      for (int z = 0; z < 64; z++) m_mem[z][m_t] <= lane[z];
      if (start || wr_en) m_err <= 1'b1;
      m_t <= m_t + 1;
    end else if (m_t == 25) begin
      if (wr_en) m_mem[wr_addr] <= wr_data;
      if (start || wr_en) m_err <= 1'b1;
      m_t <= 26;
    end else begin
      if (wr_en) m_mem[wr_addr] <= wr_data;
      m_t <= start ? 0 : -1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("busy", {31'd0, busy}, {31'd0, (m_t >= 0 && m_t <= 24)});
      check("ready", {31'd0, ready}, {31'd0, (m_t == 26)});
      check("rd_data", {7'd0, rd_data}, {7'd0, m_mem[rd_addr]});
`ifdef INV_ROTATE_ERR_EN
      check("err", {31'd0, err}, {31'd0, m_err});
`endif
    end
  end

  // All driver tasks enter and leave 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic write_word(input int z, input logic [0:24] d);
    wr_en = 1'b1; wr_addr = 6'(z); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic read_check(input int z, input logic [0:24] exp, input string name);
    rd_addr = 6'(z);
    @(negedge clk);
    check(name, {7'd0, rd_data}, {7'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic run(input int misuse_at, input int rst_at, output int n, output bit got_ready);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    got_ready = 1'b0;
    while (n < 40) begin
      if (n == misuse_at) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = '1;
      end
      if (n == rst_at) rst = 1'b1;
      @(posedge clk); n++; #1;
      start = 1'b0; wr_en = 1'b0; rst = 1'b0;
      if (ready) begin
        got_ready = 1'b1;
        break;
      end
    end
  endtask

  task automatic make_state();
    for (int z = 0; z < 64; z++) s_mem[z] = 25'($urandom);
    for (int z = 0; z < 64; z++)
      for (int l = 0; l < 25; l++)
        f_mem[z][l] = s_mem[(z - rho_tb[l] + 64) % 64][l];
  endtask

  task automatic load_fwd();
    for (int z = 0; z < 64; z++) write_word(z, f_mem[z]);
  endtask

  task automatic check_s(input string name);
    for (int z = 0; z < 64; z++) read_check(z, s_mem[z], name);
  endtask

  int n;
  bit got;

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;

    for (int z = 0; z < 64; z++) read_check(z, '0, "reset_word");
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;

    // Lane 1, r = 1: bit 1 at z=1 moves to z=0.
    write_word(1, 25'h0800000);
    run(-1, -1, n, got);
    check("lane1_ready_seen", {31'd0, got}, 32'd1);
    check("lane1_latency", n, 32'd26);
    read_check(0, 25'h0800000, "lane1_z0");
    read_check(1, 25'h0000000, "lane1_z1");

    // Lane 2, r = 62: bit 2 at z=0 moves to z=2.
    do_reset();
    write_word(0, 25'h0400000);
    run(-1, -1, n, got);
    check("lane2_latency", n, 32'd26);
    read_check(2, 25'h0400000, "lane2_z2");
    read_check(0, 25'h0000000, "lane2_z0");

    // Lane 24, r = 14: bit 24 at z=5 moves to z=55.
    do_reset();
    write_word(5, 25'h0000001);
    run(-1, -1, n, got);
    check("lane24_latency", n, 32'd26);
    read_check(55, 25'h0000001, "lane24_z55");
    read_check(5, 25'h0000000, "lane24_z5");

    for (int it = 0; it < 100; it++) begin
      make_state();
      load_fwd();
      run(-1, -1, n, got);
      check("rt_latency", n, 32'd26);
      check_s("roundtrip");
    end

    // Misuse at lane 10: ignored, timing unchanged.
    make_state();
    load_fwd();
    run(10, -1, n, got);
    check("misuse_ready_seen", {31'd0, got}, 32'd1);
    check("misuse_latency", n, 32'd26);
    check_s("misuse_array");
`ifdef INV_ROTATE_ERR_EN
    @(negedge clk);
    check("misuse_err_set", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("err_cleared", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
`endif

    // Reset at lane 10: array cleared, no ready.
    make_state();
    load_fwd();
    run(-1, 10, n, got);
    check("rstmid_no_ready", {31'd0, got}, 32'd0);
    for (int z = 0; z < 64; z++) read_check(z, '0, "rstmid_word");
    load_fwd();
    run(-1, -1, n, got);
    check("rstmid_rerun_latency", n, 32'd26);
    check_s("rstmid_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
